// File: rtl/mac_tx_frame_scheduler.sv
// rtl/mac_tx_frame_scheduler.sv - round-robin frame scheduler in front of mac_frame_generator
//
// Grants one of NUM_REQ requesters at a time, latches that requester's header
// fields, pulses the generator start, waits for done (with a watchdog), then
// holds off for an inter-packet gap before the next grant.
//
// Ports:
//   clk               clock, rising edge
//   i_rst             synchronous reset, active-high
//   i_enable          when low no new grants issue; an in-flight frame completes
//   i_req             per-requester level request
//   i_dest_address    flattened 48-bit fields, requester k at [48k+47:48k]
//   i_src_address     flattened 48-bit fields, same packing
//   i_eth_type        flattened 16-bit fields, requester k at [16k+15:16k]
//   i_payload_length  flattened 16-bit fields, same packing
//   i_gen_done        done pulse from the generator
//   o_start           one-cycle start pulse to the generator
//   o_dest_address    latched fields of the granted requester
//   o_src_address
//   o_eth_type
//   o_payload_length
//   o_grant           one-hot grant, zero when nothing is granted
//   o_busy            high whenever the scheduler is not idle
//   o_frame_count     frames completed through i_gen_done, wraps
//   o_timeout         one-cycle pulse on watchdog abort

module mac_tx_frame_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IPG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*48-1:0] i_dest_address,
  input  logic [NUM_REQ*48-1:0] i_src_address,
  input  logic [NUM_REQ*16-1:0] i_eth_type,
  input  logic [NUM_REQ*16-1:0] i_payload_length,
  input  logic                  i_gen_done,
  output logic                  o_start,
  output logic [47:0]           o_dest_address,
  output logic [47:0]           o_src_address,
  output logic [15:0]           o_eth_type,
  output logic [15:0]           o_payload_length,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_busy,
  output logic [31:0]           o_frame_count,
  output logic                  o_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int IPG_W = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;

  // Requester count at candidate width, so the wrap compare works for any NUM_REQ.
  localparam logic [IDX_W:0]   NUM_REQ_X = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_IPG       = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [47:0]         dest_q, dest_d;
  logic [47:0]         src_q, src_d;
  logic [15:0]         type_q, type_d;
  logic [15:0]         len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [IPG_W-1:0]    ipg_q, ipg_d;
  logic [31:0]         count_q, count_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;
  logic                wd_expired;
  logic                frame_end;
  logic                grant_now;

  // Round-robin search: first requesting index at or above the pointer,
  // wrapping back to 0. Candidate carries one extra bit so ptr+i cannot overflow.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (!win_found && i_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign wd_expired = (wd_q == WD_LAST);
  assign frame_end  = (state_q == S_WAIT_DONE) && (i_gen_done || wd_expired);
  assign grant_now  = (state_q == S_IDLE) && i_enable && win_found;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      type_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      ipg_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      type_q  <= type_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      ipg_q   <= ipg_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_now) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (frame_end) begin
          state_d = (IPG_CYCLES == 0) ? S_IDLE : S_IPG;
        end
      end
      S_IPG: begin
        // Leave on the cycle the counter would hit zero: exactly IPG_CYCLES cycles here.
        if (ipg_q <= IPG_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next-state: grant capture, watchdog, gap counter, frame count.
  always_comb begin
    grant_d = grant_q;
    dest_d  = dest_q;
    src_d   = src_q;
    type_d  = type_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    ipg_d   = ipg_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_now) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          dest_d  = i_dest_address[int'(win_idx)*48 +: 48];
          src_d   = i_src_address[int'(win_idx)*48 +: 48];
          type_d  = i_eth_type[int'(win_idx)*16 +: 16];
          len_d   = i_payload_length[int'(win_idx)*16 +: 16];
        end
      end
      S_START: begin
        wd_d = '0;
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WD_W'(1);
        if (frame_end) begin
          // Done wins over a coincident watchdog expiry.
          if (i_gen_done) begin
            count_d = count_q + 32'd1;
          end
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          grant_d = '0;
          ipg_d   = IPG_W'(IPG_CYCLES);
        end
      end
      S_IPG: begin
        ipg_d = ipg_q - IPG_W'(1);
      end
      default: begin
        ipg_d = ipg_q;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    o_start   = (state_q == S_START);
    o_busy    = (state_q != S_IDLE);
    o_timeout = (state_q == S_WAIT_DONE) && !i_gen_done && wd_expired;
  end

  assign o_grant          = grant_q;
  assign o_dest_address   = dest_q;
  assign o_src_address    = src_q;
  assign o_eth_type       = type_q;
  assign o_payload_length = len_q;
  assign o_frame_count    = count_q;

endmodule

// File: tb/tb_mac_tx_frame_scheduler.sv
// tb/tb_mac_tx_frame_scheduler.sv - scoreboard bench for mac_tx_frame_scheduler

module tb_mac_tx_frame_scheduler;

  localparam int N   = 4;
  localparam int IPG = 4;
  localparam int T   = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, done;
  logic [N-1:0]   req;
  logic [47:0]    dest [N];
  logic [47:0]    src  [N];
  logic [15:0]    etype[N];
  logic [15:0]    plen [N];
  logic [N*48-1:0] dest_f, src_f;
  logic [N*16-1:0] type_f, len_f;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign dest_f[48*k +: 48] = dest[k];
    assign src_f[48*k +: 48]  = src[k];
    assign type_f[16*k +: 16] = etype[k];
    assign len_f[16*k +: 16]  = plen[k];
  end

  logic          o_start, o_busy, o_timeout;
  logic [47:0]   o_dest, o_src;
  logic [15:0]   o_type, o_len;
  logic [N-1:0]  o_grant;
  logic [31:0]   o_count;

  mac_tx_frame_scheduler #(
    .NUM_REQ(N), .IPG_CYCLES(IPG), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .i_rst(rst), .i_enable(en), .i_req(req),
    .i_dest_address(dest_f), .i_src_address(src_f),
    .i_eth_type(type_f), .i_payload_length(len_f),
    .i_gen_done(done), .o_start(o_start),
    .o_dest_address(o_dest), .o_src_address(o_src),
    .o_eth_type(o_type), .o_payload_length(o_len),
    .o_grant(o_grant), .o_busy(o_busy),
    .o_frame_count(o_count), .o_timeout(o_timeout)
  );

  typedef struct {
    int          cyc;
    logic [N-1:0] grant;
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] et;
    logic [15:0] pl;
    logic [31:0] cnt;
  } rec_t;

  rec_t sq[$];
  int   tq[$];
  int   dq[$];

  int          cyc = 0;
  int          free_edge = 0;
  int          g_last = 0;
  int          grant_end = -1;
  int          busy_end = -1;
  logic [N-1:0] g_onehot = '0;
  int          ptr = 0;
  logic [31:0] m_count = '0;
  int          force_d = -1;
  bit          stim_on = 1'b0;
  int          cool[N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_d();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(T + 1, T + IPG + 1);
    if (r == 2) return T;
    if (r == 3) return 1;
    return $urandom_range(2, 14);
  endfunction

  task automatic new_fields(input int k);
    dest[k]  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    src[k]   = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    etype[k] = 16'($urandom);
    plen[k]  = 16'($urandom);
  endtask

  // Reference model: decides each grant from the rules (eligibility window,
  // round-robin from the pointer) and predicts start, timeout and busy windows.
  initial begin
    int w, c, d, e_end;
    rec_t r;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        ptr = 0;
        m_count = '0;
        free_edge = cyc + 1;
        grant_end = -1;
        busy_end = -1;
        sq.delete();
        tq.delete();
        dq.delete();
      end else if (cyc >= free_edge && en && (req != '0)) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          c = (ptr + i) % N;
          if (w < 0 && req[c]) w = c;
        end
        d = (force_d >= 0) ? force_d : pick_d();
        r.cyc = cyc;
        r.grant = N'(1) << w;
        r.dest = dest[w];
        r.src = src[w];
        r.et = etype[w];
        r.pl = plen[w];
        r.cnt = m_count;
        sq.push_back(r);
        dq.push_back(d);
        g_last = cyc;
        g_onehot = r.grant;
        if (d >= 1 && d <= T) begin
          e_end = cyc + d + 1;
          m_count = m_count + 32'd1;
        end else begin
          e_end = cyc + T + 1;
          tq.push_back(cyc + T);
        end
        grant_end = e_end - 1;
        busy_end = e_end + IPG - 1;
        free_edge = e_end + IPG + 1;
        ptr = (w + 1) % N;
      end
    end
  end

  // Generator stand-in: raises done D cycles after each observed start.
  initial begin
    int cnt;
    cnt = -1;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (rst) begin
        cnt = -1;
      end else if (o_start) begin
        cnt = (dq.size() > 0) ? dq.pop_front() : 0;
        if (cnt == 0) cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          cnt = -1;
        end
      end
    end
  end

  // Monitor: pops expected records when the DUT presents start / timeout.
  initial begin
    rec_t r;
    int t;
    forever begin
      @(negedge clk);
      chk("busy", 64'(o_busy), 64'(cyc >= g_last && cyc <= busy_end));
      chk("grant_level", 64'(o_grant), (cyc >= g_last && cyc <= grant_end) ? 64'(g_onehot) : 64'd0);
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        r = sq.pop_front();
        checks++;
        errors++;
        $display("FAIL start_missed: no start seen, expected at cycle %0d", r.cyc);
      end
      while (tq.size() > 0 && tq[0] < cyc) begin
        t = tq.pop_front();
        checks++;
        errors++;
        $display("FAIL timeout_missed: no timeout seen, expected at cycle %0d", t);
      end
      if (o_start) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: start at cycle %0d, none expected", cyc);
        end else begin
          r = sq.pop_front();
          chk("start_cycle", 64'(cyc), 64'(r.cyc));
          chk("start_grant", 64'(o_grant), 64'(r.grant));
          chk("start_dest", 64'(o_dest), 64'(r.dest));
          chk("start_src", 64'(o_src), 64'(r.src));
          chk("start_type", 64'(o_type), 64'(r.et));
          chk("start_len", 64'(o_len), 64'(r.pl));
          chk("start_count", 64'(o_count), 64'(r.cnt));
        end
      end
      if (o_timeout) begin
        if (tq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL timeout_unexpected: timeout at cycle %0d, none expected", cyc);
        end else begin
          t = tq.pop_front();
          chk("timeout_cycle", 64'(cyc), 64'(t));
        end
      end
    end
  end

  // Requesters: drop on grant, then optionally re-raise with fresh fields.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (req[k] && o_grant[k]) begin
        req[k] = 1'b0;
        cool[k] = $urandom_range(1, 6);
        new_fields(k);
      end else if (!req[k]) begin
        if (cool[k] > 0) begin
          cool[k]--;
        end else if (stim_on && !o_grant[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          new_fields(k);
        end
      end
    end
    if (stim_on) en = ($urandom_range(0, 19) != 0);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (req == '0 && !o_busy && sq.size() == 0 && cyc > busy_end) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req = '0;
    for (int k = 0; k < N; k++) begin
      cool[k] = 0;
      new_fields(k);
    end
    repeat (3) tick();
    chk("rst_start", 64'(o_start), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    chk("rst_dest", 64'(o_dest), 64'd0);
    rst = 1'b0;
    tick();

    // Single requester, done 20 cycles after start.
    en = 1'b1;
    force_d = 20;
    dest[2] = 48'hAABB_CCDD_EEFF;
    req = 4'b0100;
    tick();
    chk("t1_start", 64'(o_start), 64'd1);
    chk("t1_grant", 64'(o_grant), 64'h4);
    chk("t1_dest", 64'(o_dest), 64'hAABB_CCDD_EEFF);
    wait_idle("t1_idle");
    chk("t1_count", 64'(o_count), 64'd1);

    // Randomized traffic.
    force_d = -1;
    stim_on = 1'b1;
    repeat (3000) tick();
    stim_on = 1'b0;
    en = 1'b1;
    wait_idle("rand_idle");
    chk("rand_count", 64'(o_count), 64'(m_count));

    // Enable low blocks grants; dropping enable mid-frame lets it finish.
    en = 1'b0;
    req = 4'b0001;
    repeat (30) tick();
    chk("en_busy", 64'(o_busy), 64'd0);
    chk("en_grant", 64'(o_grant), 64'd0);
    force_d = 8;
    en = 1'b1;
    wait_start("en_start");
    en = 1'b0;
    req = req | 4'b0010;
    repeat (40) tick();
    chk("en_busy2", 64'(o_busy), 64'd0);
    chk("en_grant2", 64'(o_grant), 64'd0);
    chk("en_count", 64'(o_count), 64'(m_count));
    req = '0;
    en = 1'b1;
    wait_idle("en_idle");

    // Reset during WAIT_DONE, then pointer restarts at 0.
    force_d = 0;
    req = 4'b0100;
    wait_start("rst2_start");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst2_busy", 64'(o_busy), 64'd0);
    chk("rst2_grant", 64'(o_grant), 64'd0);
    chk("rst2_count", 64'(o_count), 64'd0);
    rst = 1'b0;
    force_d = 5;
    req = 4'b1001;
    tick();
    chk("rst2_first_start", 64'(o_start), 64'd1);
    chk("rst2_first_grant", 64'(o_grant), 64'h1);
    wait_idle("rst2_idle");
    chk("rst2_final_count", 64'(o_count), 64'd2);
    chk("sq_empty", 64'(sq.size()), 64'd0);
    chk("tq_empty", 64'(tq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_frame_scheduler.md
Name: mac_tx_frame_scheduler

Overview:
Round-robin arbiter and sequencer that shares one mac_frame_generator (feeding MII_gen) between NUM_REQ frame requesters. Each requester presents its header fields and a level request. The scheduler grants one requester at a time, latches and drives that requester's fields to the generator, pulses the generator start, waits for done (with a watchdog), then enforces an inter-packet gap before the next grant. It sits directly upstream of mac_frame_generator in mac_mii_top-style integrations.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
IPG_CYCLES, 12, idle clock cycles enforced after each frame ends (0 allowed)
TIMEOUT_CYCLES, 4096, max cycles to wait for i_gen_done before abort (>=2)

Ports:
clk  input  1  single clock, rising edge
i_rst  input  1  synchronous reset, active-high
i_enable  input  1  level; when low no new grants issue, in-flight frame completes
i_req  input  NUM_REQ  per-requester level request
i_dest_address  input  NUM_REQ*48  flattened; requester k at [48k+47:48k]
i_src_address  input  NUM_REQ*48  flattened, same packing
i_eth_type  input  NUM_REQ*16  flattened; requester k at [16k+15:16k]
i_payload_length  input  NUM_REQ*16  flattened, same packing
i_gen_done  input  1  done pulse from mac_frame_generator
o_start  output  1  one-cycle start pulse to generator
o_dest_address  output  48  latched fields of granted requester
o_src_address  output  48
o_eth_type  output  16
o_payload_length  output  16
o_grant  output  NUM_REQ  one-hot grant, zero when no grant
o_busy  output  1  high whenever state != IDLE
o_frame_count  output  32  frames completed via i_gen_done, wraps 2^32-1 -> 0
o_timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (i_rst=1 at edge): state IDLE; all outputs 0; rr pointer 0; watchdog and IPG counters 0. Reset overrides any state, including mid-frame. o_start is low in the cycle after reset.
- States: IDLE, START, WAIT_DONE, IPG.
- IDLE: if i_enable=1 and |i_req, pick winner = first set bit of i_req searching from pointer upward with wrap to 0.
  - At that edge, register o_grant (one-hot), the winner's four fields and winner index; go to START.
  - Otherwise stay in IDLE with o_grant=0.
- START: o_start=1 for exactly this cycle; watchdog cleared; next state WAIT_DONE. Grant latency: request sampled at edge t -> o_grant and o_start high in cycle t+1.
- WAIT_DONE: watchdog increments each cycle.
  - i_gen_done=1: o_frame_count += 1; go to IPG.
  - Else if watchdog reaches TIMEOUT_CYCLES-1: o_timeout=1 for one cycle; count unchanged; go to IPG.
  - i_gen_done has priority over timeout in the same cycle.
  - i_gen_done outside WAIT_DONE is ignored.
- On leaving WAIT_DONE (done or timeout): rr pointer := (winner index + 1) mod NUM_REQ; o_grant := 0; IPG counter := IPG_CYCLES.
  - If IPG_CYCLES=0, go directly to IDLE instead of IPG.
- IPG: counter decrements each cycle; transition to IDLE on the cycle it would reach 0. Exactly IPG_CYCLES cycles are spent in IPG; no grant is possible during IPG.
- Output fields hold their values from grant until the next grant; they are not cleared on returning to IDLE (only reset clears them).
- i_req or i_enable deasserting after grant does not abort the frame. Requesters hold i_req until they see o_grant.
- Input field changes after grant do not affect the outputs.
- Index width is $clog2(NUM_REQ); the pointer wrap uses an explicit compare for non-power-of-2 NUM_REQ.

Test Plan:
1. Reset, i_enable=1, i_req=4'b0100 with dest 0xAABBCCDDEEFF held; done after 20 cycles -> o_grant=0100 and o_start pulse one cycle after request; o_dest_address=0xAABBCCDDEEFF; o_frame_count=1; pointer=3.
2. i_req=4'b1111 held, generator done 10 cycles after each start -> grant order 0,1,2,3,0. Consecutive o_start pulses are 1+1+10+12 = 24 cycles apart (IPG_CYCLES=12).
3. IPG_CYCLES=0, i_req=4'b0011 -> next grant lands in the cycle after IDLE re-entry; no IPG cycles occur.
4. TIMEOUT_CYCLES=16, grant requester 1, never assert done -> o_timeout pulses 16 cycles after START; o_frame_count unchanged; pointer=2; IPG then IDLE.
5. i_enable=0 with i_req=4'b0001 -> no grant and o_busy=0. Drop i_enable mid-frame -> frame completes, count increments, no further grants.
6. Assert i_rst during WAIT_DONE -> next cycle o_busy=0, o_grant=0, o_frame_count=0. A later request to requester 3 with i_req=4'b1001 grants requester 0 first (pointer reset to 0).
